hd_file_writer: RTL
===================

Name: hd_file_writer

Overview:
- Write-side counterpart of the boot-time HD file loader: lays files onto the HD image in the exact format the loader parses.
- Format per file: a BEGIN_FILE marker word, the payload words, an END_FILE marker word, then an HD_END terminator word.
- Sits between the CPU file-syscall path (CREATE_FILE/CLOSE_FILE plus a data stream) and the HD write port.
- Reports each file's start/end page descriptor in the same {start[15:0], end[15:0]} packing the loader uses.

Parameters:
ADDR_W, 16, HD word-address width
BASE_ADDR, 16'h0000, first HD address used for files; free pointer reset value
LIMIT_ADDR, 16'hFFFF, last writable HD address (inclusive)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
cmd_create  in  1  one-cycle pulse: open a new file (CREATE_FILE issued)
cmd_close  in  1  one-cycle pulse: close the open file (CLOSE_FILE issued)
wr_valid  in  1  payload word available
wr_data  in  32  payload word
wr_ready  out  1  payload word accepted when wr_valid&wr_ready at rising edge
hd_we  out  1  HD write strobe
hd_addr  out  ADDR_W  HD write address
hd_wdata  out  32  HD write data
page  out  32  [31:16] file start address (BEGIN marker), [15:0] END marker address
save_page  out  1  one-cycle pulse: page is valid and final
file_open  out  1  high while the FSM is not in IDLE
full_err  out  1  sticky overflow flag

Behaviour:
- Marker words: BEGIN = {6'b010101, 26'b0}; END = {6'b010110, 26'b0}; HD_END = {6'b011000, 26'b0}.
- Reset (async): state=IDLE, ptr=BASE_ADDR, page=0, save_page=0, full_err=0. All hd_* outputs read 0 while in IDLE.
- States: IDLE, HEAD, DATA, TAIL, TERM. hd_* outputs are combinational from state/ptr/handshake. hd_addr=ptr whenever hd_we=1.
- IDLE:
  - cmd_create with ptr+2 <= LIMIT_ADDR -> HEAD.
  - cmd_create with ptr+2 > LIMIT_ADDR -> stay IDLE, full_err<=1.
  - cmd_close is ignored.
- HEAD (1 cycle): hd_we=1, hd_wdata=BEGIN. At the edge: page[31:16]<=ptr, ptr<=ptr+1 -> DATA.
- DATA:
  - wr_ready = ~cmd_close & (ptr+2 <= LIMIT_ADDR). Two slots are always reserved for END and HD_END.
  - On wr_valid&wr_ready: hd_we=1, hd_wdata=wr_data, ptr<=ptr+1.
  - wr_valid while wr_ready is low because of the space limit -> full_err<=1; the word is not accepted.
  - cmd_close -> TAIL. If wr_valid is high in the same cycle, that word is not accepted; the producer holds it.
  - cmd_create is ignored.
- TAIL (1 cycle): hd_we=1, hd_wdata=END. At the edge: page[15:0]<=ptr, ptr<=ptr+1 -> TERM.
- TERM (1 cycle): hd_we=1, hd_wdata=HD_END. ptr is NOT incremented, so the next file's BEGIN overwrites the terminator. save_page<=1 at the edge -> IDLE.
- save_page is high for exactly the first IDLE cycle after TERM, then returns to 0. page holds its value until the next HEAD/TAIL update.
- Latency:
  - cmd_create at edge N -> BEGIN written in cycle N+1.
  - cmd_close at edge M -> END in M+1, HD_END in M+2, save_page in M+3.
- Empty file (close right after create): BEGIN, END, HD_END at consecutive addresses; page = {a, a+1}.
- full_err clears only on reset.
- Reset mid-file: the file is abandoned with no END/HD_END written; ptr returns to BASE_ADDR and the next file overwrites from there.
- Address arithmetic is ADDR_W-wide. Wrap-around is impossible because LIMIT_ADDR gates every increment; compare using ADDR_W+1 bits so ptr+2 does not overflow.

Test Plan:
- BASE=0x0010: create; send 0xAAAA0001, 0xAAAA0002; close -> writes @0x10=0x54000000, @0x11=0xAAAA0001, @0x12=0xAAAA0002, @0x13=0x58000000, @0x14=0x60000000; save_page pulses once with page=0x00100013; ptr=0x14.
- Second file after the first: create; send 0x1; close -> BEGIN @0x14 (overwrites HD_END), data @0x15, END @0x16, HD_END @0x17; page=0x00140016.
- Empty file at BASE=0x0010: create then close -> page=0x00100011, three writes total, wr_ready never sampled.
- LIMIT=0x0014, BASE=0x0010: create, stream 5 words with wr_valid held -> only 0x11, 0x12 accepted; wr_ready low at ptr=0x13; full_err=1; close -> END @0x13, HD_END @0x14.
- wr_valid and cmd_close in the same cycle -> word not written, wr_ready=0 that cycle, END written next cycle; cmd_create during DATA ignored.
- Assert reset while in DATA after 2 words -> all outputs 0 immediately (async); subsequent create writes BEGIN at BASE_ADDR.

Source files
------------

// File: rtl/hd_file_writer.sv
// hd_file_writer
// Lays files onto the HD image in the layout the boot-time loader parses:
// BEGIN marker, payload words, END marker, HD_END terminator. The terminator
// is written without advancing the free pointer, so the next file's BEGIN
// lands on top of it and the image always ends in exactly one HD_END.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   cmd_create           pulse: open a new file
//   cmd_close            pulse: close the open file
//   wr_valid/wr_data     payload stream from the CPU side
//   wr_ready             payload word accepted on wr_valid & wr_ready
//   hd_we/hd_addr/hd_wdata  HD write port (all zero when not writing)
//   page                 {BEGIN address, END address} of the last file
//   save_page            pulse: page is final
//   file_open            high while a file is being written
//   full_err             sticky: a create or payload word hit the limit
module hd_file_writer #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_W-1:0] LIMIT_ADDR = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_create,
    input  logic              cmd_close,
    input  logic              wr_valid,
    input  logic [31:0]       wr_data,
    output logic              wr_ready,
    output logic              hd_we,
    output logic [ADDR_W-1:0] hd_addr,
    output logic [31:0]       hd_wdata,
    output logic [31:0]       page,
    output logic              save_page,
    output logic              file_open,
    output logic              full_err
);

    localparam logic [31:0] BEGIN_WORD  = {6'b010101, 26'b0};
    localparam logic [31:0] END_WORD    = {6'b010110, 26'b0};
    localparam logic [31:0] HD_END_WORD = {6'b011000, 26'b0};

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        DATA,
        TAIL,
        TERM
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic              has_room;
    logic              ptr_inc;
    logic              set_full;

    // Two slots must stay free for END and HD_END. The extra bit keeps
    // ptr+2 from wrapping when ptr sits near the top of the address space.
    assign has_room = ({1'b0, ptr} + (ADDR_W+1)'(2)) <= {1'b0, LIMIT_ADDR};

    assign file_open = (state != IDLE);
    assign hd_addr   = hd_we ? ptr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        hd_we      = 1'b0;
        hd_wdata   = '0;
        ptr_inc    = 1'b0;
        set_full   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_create) begin
                    if (has_room) begin
                        state_next = HEAD;
                    end else begin
                        set_full = 1'b1;
                    end
                end
            end
            HEAD: begin
                hd_we      = 1'b1;
                hd_wdata   = BEGIN_WORD;
                ptr_inc    = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                // A close wins over a simultaneous payload word; the producer
                // keeps holding that word.
                wr_ready = ~cmd_close & has_room;
                if (wr_valid && wr_ready) begin
                    hd_we    = 1'b1;
                    hd_wdata = wr_data;
                    ptr_inc  = 1'b1;
                end
                if (wr_valid && !has_room) begin
                    set_full = 1'b1;
                end
                if (cmd_close) begin
                    state_next = TAIL;
                end
            end
            TAIL: begin
                hd_we      = 1'b1;
                hd_wdata   = END_WORD;
                ptr_inc    = 1'b1;
                state_next = TERM;
            end
            TERM: begin
                hd_we      = 1'b1;
                hd_wdata   = HD_END_WORD;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= BASE_ADDR;
            page      <= '0;
            save_page <= 1'b0;
            full_err  <= 1'b0;
        end else begin
            if (ptr_inc) begin
                ptr <= ptr + ADDR_W'(1);
            end
            if (state == HEAD) begin
                page[31:16] <= 16'(ptr);
            end
            if (state == TAIL) begin
                page[15:0] <= 16'(ptr);
            end
            save_page <= (state == TERM);
            if (set_full) begin
                full_err <= 1'b1;
            end
        end
    end

endmodule
